decode_stage: RTL and testbench

- Registered, parametrised RV32I/E instruction decode stage with valid/ready handshakes on both sides.
- Accepts fetched instruction words plus their PC, and produces field, regfile-control, immediate and illegal-instruction outputs one cycle later.
- An optional two-entry skid buffer keeps the input ready path free of combinational dependence on downstream stall.
- Sits between the fetch unit and the regfile/ALU issue logic; supports pipeline flush.

---
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-issue handshake bundle for decode_stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);

  // input side (fetch -> decode)
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] pc_i;

  // output side (decode -> issue)
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [6:0]      opcode_o;
  logic [2:0]      funct3_o;
  logic [6:0]      funct7_o;
  logic [4:0]      rs1_o;
  logic            rs1_rd_o;
  logic [4:0]      rs2_o;
  logic            rs2_rd_o;
  logic [4:0]      rd_o;
  logic            rd_wr_o;
  logic [XLEN-1:0] immed_o;
  logic            illegal_o;

  // decode stage view
  modport slave (
    input  in_valid_i, inst_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, opcode_o, funct3_o, funct7_o,
           rs1_o, rs1_rd_o, rs2_o, rs2_rd_o, rd_o, rd_wr_o, immed_o, illegal_o
  );

  // fetch/issue environment view
  modport master (
    output in_valid_i, inst_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, opcode_o, funct3_o, funct7_o,
           rs1_o, rs1_rd_o, rs2_o, rs2_rd_o, rd_o, rd_wr_o, immed_o, illegal_o
  );

endinterface

// File: rtl/decode_stage.sv
// RV32I/E decode stage: combinational decode of the incoming word, registered
// into an output bundle with an optional two-entry skid buffer.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          SKID_EN  = 1'b1,
  parameter bit          ENABLE_M = 1'b0,
  parameter bit          RV_E     = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  decode_stage_if.slave  io
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic            rs1_rd;
    logic [4:0]      rs2;
    logic            rs2_rd;
    logic [4:0]      rd;
    logic            rd_wr;
    logic [XLEN-1:0] immed;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  logic [31:0]     w_inst;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_rs1_use;
  logic            w_rs2_use;
  logic            w_rd_use;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;
  bundle_t         w_dec;

  state_e  r_state;
  state_e  w_state_nxt;
  logic    r_out_valid;
  logic    r_in_ready;
  bundle_t r_out;
  bundle_t r_skid;
  logic    w_accept;
  logic    w_load_out;
  logic    w_load_skid;
  logic    w_skid_to_out;

  assign w_inst   = io.inst_i;
  assign w_opcode = w_inst[6:0];
  assign w_funct3 = w_inst[14:12];
  assign w_funct7 = w_inst[31:25];
  assign w_rs1    = w_inst[19:15];
  assign w_rs2    = w_inst[24:20];
  assign w_rd     = w_inst[11:7];

  // Field usage, legality and immediate selection for the incoming word.
  always_comb begin
    w_rs1_use = 1'b0;
    w_rs2_use = 1'b0;
    w_rd_use  = 1'b0;
    w_illegal = 1'b0;
    w_imm     = '0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_rd_use = 1'b1;
        w_imm    = XLEN'($signed({w_inst[31:12], 12'b0}));
      end
      OPC_JAL: begin
        w_rd_use = 1'b1;
        w_imm    = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20],
                                  w_inst[30:21], 1'b0}));
      end
      OPC_JALR: begin
        w_rs1_use = 1'b1;
        w_rd_use  = 1'b1;
        w_imm     = XLEN'($signed(w_inst[31:20]));
        if (w_funct3 != 3'b000) w_illegal = 1'b1;
      end
      OPC_BRANCH: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_imm     = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25],
                                   w_inst[11:8], 1'b0}));
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) w_illegal = 1'b1;
      end
      OPC_LOAD: begin
        w_rs1_use = 1'b1;
        w_rd_use  = 1'b1;
        w_imm     = XLEN'($signed(w_inst[31:20]));
        if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
          w_illegal = 1'b1;
      end
      OPC_STORE: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_imm     = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
        if (w_funct3 >= 3'b011) w_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        w_rs1_use = 1'b1;
        w_rd_use  = 1'b1;
        w_imm     = XLEN'($signed(w_inst[31:20]));
        // shift-immediates carry funct7 in the upper immediate bits
        if (w_funct3 == 3'b001 && w_funct7 != F7_BASE) w_illegal = 1'b1;
        if (w_funct3 == 3'b101 && w_funct7 != F7_BASE && w_funct7 != F7_ALT)
          w_illegal = 1'b1;
      end
      OPC_OP: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_rd_use  = 1'b1;
        if (!((w_funct7 == F7_BASE) ||
              (w_funct7 == F7_ALT && (w_funct3 == 3'b000 || w_funct3 == 3'b101)) ||
              (ENABLE_M && w_funct7 == F7_MUL)))
          w_illegal = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        w_imm = XLEN'($signed(w_inst[31:20]));
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_inst[1:0] != 2'b11) w_illegal = 1'b1;
    if (RV_E && ((w_rs1_use && w_rs1[4]) || (w_rs2_use && w_rs2[4]) ||
                 (w_rd_use && w_rd[4])))
      w_illegal = 1'b1;
  end

  // Assemble the bundle; illegal words keep their raw fields but lose enables.
  always_comb begin
    w_dec         = '0;
    w_dec.pc      = io.pc_i;
    w_dec.opcode  = w_opcode;
    w_dec.funct3  = w_funct3;
    w_dec.funct7  = w_funct7;
    w_dec.rs1     = w_rs1;
    w_dec.rs2     = w_rs2;
    w_dec.rd      = w_rd;
    w_dec.rs1_rd  = w_rs1_use && !w_illegal;
    w_dec.rs2_rd  = w_rs2_use && !w_illegal;
    w_dec.rd_wr   = w_rd_use && !w_illegal && (w_rd != 5'd0);
    w_dec.immed   = w_illegal ? '0 : w_imm;
    w_dec.illegal = w_illegal;
  end

  assign w_accept = io.in_valid_i && io.in_ready_o;

  // Next-state and buffer-steering logic; flush overrides every other event.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_load_out  = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept && io.out_ready_i) begin
            w_load_out = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_SKID;
            w_load_skid = 1'b1;
          end else if (io.out_ready_i) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (io.out_ready_i) begin
            w_state_nxt   = ST_FULL;
            w_skid_to_out = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register plus registered valid/ready flags derived from next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_SKID);
    end
  end

  // Output and skid payload registers; contents survive a flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out)         r_out <= w_dec;
      else if (w_skid_to_out) r_out <= r_skid;
      if (w_load_skid)        r_skid <= w_dec;
    end
  end

  // Without the skid entry, ready may look through to the consumer.
  assign io.in_ready_o  = SKID_EN ? r_in_ready : (!r_out_valid || io.out_ready_i);
  assign io.out_valid_o = r_out_valid;
  assign io.pc_o        = r_out.pc;
  assign io.opcode_o    = r_out.opcode;
  assign io.funct3_o    = r_out.funct3;
  assign io.funct7_o    = r_out.funct7;
  assign io.rs1_o       = r_out.rs1;
  assign io.rs1_rd_o    = r_out.rs1_rd;
  assign io.rs2_o       = r_out.rs2;
  assign io.rs2_rd_o    = r_out.rs2_rd;
  assign io.rd_o        = r_out.rd;
  assign io.rd_wr_o     = r_out.rd_wr;
  assign io.immed_o     = r_out.immed;
  assign io.illegal_o   = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard on the skid-buffered
// instance plus directed checks on an M-enabled single-register instance.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wr;
    logic        r1;
    logic        r2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    vec_t        v;
  } exp_t;

  localparam int unsigned NVEC = 17;

  logic clk;
  logic rst_n;
  logic flush;
  logic rand_bp;
  int   n_checks;
  int   n_fail;
  vec_t vec [NVEC];
  exp_t exp_q [$];
  logic [31:0] pc_ctr;

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage_if #(.XLEN(32)) bus_m ();

  decode_stage #(.XLEN(32), .SKID_EN(1'b1), .ENABLE_M(1'b0), .RV_E(1'b0)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .io     (bus)
  );

  decode_stage #(.XLEN(32), .SKID_EN(1'b0), .ENABLE_M(1'b1), .RV_E(1'b0)) dut_m (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .io     (bus_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one cycle: move to just after the rising edge, optionally randomise backpressure
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bp) bus.out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // offer vec[idx] until accepted; push the expected bundle at the accepting edge
  task automatic send(input int idx);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.inst_i     = vec[idx].inst;
    bus.pc_i       = pc_ctr;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      e.pc = pc_ctr;
      e.v  = vec[idx];
      exp_q.push_back(e);
    end else begin
      chk("accept_timeout", 64'(bus.in_ready_o), 64'd1);
    end
    step();
    bus.in_valid_i = 1'b0;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  // output monitor: scoreboard pop on transfer, stability while stalled
  logic        hold;
  logic [63:0] held;
  logic        prev_flush;
  exp_t        mon_e;

  initial begin
    hold = 1'b0;
    held = '0;
    prev_flush = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold && !prev_flush) begin
        chk("hold_valid", 64'(bus.out_valid_o), 64'd1);
        chk("hold_data", {bus.pc_o, bus.immed_o}, held);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(bus.out_valid_o), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pc",      64'(bus.pc_o),      64'(mon_e.pc));
          chk("rd",      64'(bus.rd_o),      64'(mon_e.v.rd));
          chk("rd_wr",   64'(bus.rd_wr_o),   64'(mon_e.v.wr));
          chk("rs1_rd",  64'(bus.rs1_rd_o),  64'(mon_e.v.r1));
          chk("rs2_rd",  64'(bus.rs2_rd_o),  64'(mon_e.v.r2));
          chk("immed",   64'(bus.immed_o),   64'(mon_e.v.imm));
          chk("illegal", 64'(bus.illegal_o), 64'(mon_e.v.ill));
          chk("opcode",  64'(bus.opcode_o),  64'(mon_e.v.inst[6:0]));
        end
      end
      hold = bus.out_valid_o && !bus.out_ready_i;
      held = {bus.pc_o, bus.immed_o};
    end
    prev_flush = flush;
  end

  initial begin
    //            inst          rd     wr    r1    r2    imm           ill
    vec[0]  = '{32'h00500093, 5'd1,  1'b1, 1'b1, 1'b0, 32'h00000005, 1'b0}; // addi x1,x0,5
    vec[1]  = '{32'h0020A423, 5'd8,  1'b0, 1'b1, 1'b1, 32'h00000008, 1'b0}; // sw x2,8(x1)
    vec[2]  = '{32'hFE000EE3, 5'd29, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0}; // beq -4
    vec[3]  = '{32'h123452B7, 5'd5,  1'b1, 1'b0, 1'b0, 32'h12345000, 1'b0}; // lui x5
    vec[4]  = '{32'h00308113, 5'd2,  1'b1, 1'b1, 1'b0, 32'h00000003, 1'b0}; // addi x2,x1,3
    vec[5]  = '{32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1}; // all zero
    vec[6]  = '{32'h022081B3, 5'd3,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1}; // mul, no M
    vec[7]  = '{32'h008000EF, 5'd1,  1'b1, 1'b0, 1'b0, 32'h00000008, 1'b0}; // jal x1,8
    vec[8]  = '{32'h000090E7, 5'd1,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1}; // jalr f3=1
    vec[9]  = '{32'h00000013, 5'd0,  1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0}; // nop, rd=0
    vec[10] = '{32'h402081B3, 5'd3,  1'b1, 1'b1, 1'b1, 32'h00000000, 1'b0}; // sub
    vec[11] = '{32'h4020C1B3, 5'd3,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1}; // xor w/ f7 alt
    vec[12] = '{32'h00000073, 5'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0}; // ecall
    vec[13] = '{32'h02009093, 5'd1,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1}; // slli bad f7
    vec[14] = '{32'h4010D093, 5'd1,  1'b1, 1'b1, 1'b0, 32'h00000401, 1'b0}; // srai x1,x1,1
    vec[15] = '{32'h0000B083, 5'd1,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1}; // ld on RV32
    vec[16] = '{32'hFFF0A083, 5'd1,  1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0}; // lw x1,-1(x1)

    n_checks = 0;
    n_fail   = 0;
    pc_ctr   = 32'h00001000;
    rand_bp  = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    bus.in_valid_i   = 1'b0;
    bus.inst_i       = '0;
    bus.pc_i         = '0;
    bus.out_ready_i  = 1'b0;
    bus_m.in_valid_i  = 1'b0;
    bus_m.inst_i      = '0;
    bus_m.pc_i        = '0;
    bus_m.out_ready_i = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
    chk("rst_immed",     64'(bus.immed_o),     64'd0);
    chk("rst_pc",        64'(bus.pc_o),        64'd0);
    chk("rst_rd",        64'(bus.rd_o),        64'd0);
    rst_n = 1'b1;
    step();

    // single instruction, one-cycle latency
    bus.out_ready_i = 1'b1;
    send(0);
    chk("latency_valid", 64'(bus.out_valid_o), 64'd1);
    chk("latency_rd",    64'(bus.rd_o),        64'd1);

    // back-to-back
    send(1);
    send(2);
    idle(3);

    // stall with skid fill
    bus.out_ready_i = 1'b0;
    send(3);
    idle(3);
    send(4);
    chk("skid_in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("skid_head_rd",  64'(bus.rd_o),       64'd5);
    idle(2);
    bus.out_ready_i = 1'b1;
    idle(4);
    chk("q_empty_stall", 64'(exp_q.size()), 64'd0);

    // legality sweep under random backpressure
    rand_bp = 1'b1;
    for (int i = 5; i < int'(NVEC); i++) begin
      send(i);
      idle(int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 5; i++) send(i);
    rand_bp = 1'b0;
    bus.out_ready_i = 1'b1;
    idle(6);
    chk("q_empty_sweep", 64'(exp_q.size()), 64'd0);

    // flush while in SKID with a same-cycle offer
    bus.out_ready_i = 1'b0;
    send(0);
    send(3);
    chk("pre_flush_in_ready", 64'(bus.in_ready_o), 64'd0);
    bus.in_valid_i = 1'b1;
    bus.inst_i     = vec[4].inst;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_in_ready",  64'(bus.in_ready_o),  64'd1);
    chk("flush_keep_rd",   64'(bus.rd_o),        64'd1);
    chk("flush_keep_imm",  64'(bus.immed_o),     64'd5);

    // flush drops an accept that would otherwise land in EMPTY
    bus.in_valid_i = 1'b1;
    bus.inst_i     = vec[3].inst;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("flush_drop_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_drop_rd",    64'(bus.rd_o),        64'd1);
    bus.out_ready_i = 1'b1;
    idle(3);
    chk("q_empty_flush", 64'(exp_q.size()), 64'd0);

    // asynchronous reset mid-stream
    bus.out_ready_i = 1'b0;
    send(3);
    chk("pre_rst_valid", 64'(bus.out_valid_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("arst_in_ready",  64'(bus.in_ready_o),  64'd1);
    chk("arst_immed",     64'(bus.immed_o),     64'd0);
    chk("arst_rd",        64'(bus.rd_o),        64'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    send(0);
    chk("post_rst_valid", 64'(bus.out_valid_o), 64'd1);
    idle(3);
    chk("q_empty_rst", 64'(exp_q.size()), 64'd0);

    // M-enabled, single-register instance
    bus_m.out_ready_i = 1'b0;
    bus_m.inst_i      = 32'h022081B3;
    bus_m.pc_i        = 32'h00000200;
    bus_m.in_valid_i  = 1'b1;
    #1;
    chk("m_in_ready_empty", 64'(bus_m.in_ready_o), 64'd1);
    step();
    bus_m.in_valid_i = 1'b0;
    chk("m_valid",    64'(bus_m.out_valid_o), 64'd1);
    chk("m_illegal",  64'(bus_m.illegal_o),   64'd0);
    chk("m_rd",       64'(bus_m.rd_o),        64'd3);
    chk("m_rd_wr",    64'(bus_m.rd_wr_o),     64'd1);
    chk("m_rs2_rd",   64'(bus_m.rs2_rd_o),    64'd1);
    chk("m_pc",       64'(bus_m.pc_o),        64'h200);
    #1;
    chk("m_in_ready_stall", 64'(bus_m.in_ready_o), 64'd0);
    bus_m.out_ready_i = 1'b1;
    bus_m.inst_i      = vec[0].inst;
    bus_m.pc_i        = 32'h00000204;
    bus_m.in_valid_i  = 1'b1;
    #1;
    chk("m_in_ready_drain", 64'(bus_m.in_ready_o), 64'd1);
    step();
    bus_m.in_valid_i = 1'b0;
    chk("m_b2b_valid", 64'(bus_m.out_valid_o), 64'd1);
    chk("m_b2b_rd",    64'(bus_m.rd_o),        64'd1);
    chk("m_b2b_imm",   64'(bus_m.immed_o),     64'd5);
    step();
    chk("m_drained", 64'(bus_m.out_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
